microwave_timer_ctrl: RTL and testbench

Sequencer for the microwave cook timer. It captures the cook time from the keypad as three BCD digits (minutes, tens of seconds, ones of seconds). It loads them into the existing cascaded countdown digit counters, then enables the countdown once per second while cooking. It handles door-open and stop/clear pauses, detects 0:00, and drives the magnetron and end-of-cook beeper.

---
 rtl/microwave_pkg.sv | 22 ++
 rtl/keypad_preset_reg.sv | 32 +++
 rtl/microwave_timer_ctrl.sv | 107 ++++++++++
 tb/tb_microwave_timer_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave cook-timer sequencer.
// Cook time is held as three BCD digits: minutes, tens of seconds and ones of seconds.
package microwave_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COOK  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t MAX_DIGIT = 4'd9;
  localparam bcd_t MAX_TENS  = 4'd5;

  // A new key shifts the current ones digit into tens, so that digit must still be a legal tens value.
  function automatic logic key_legal(input bcd_t digit, input bcd_t cur_ones);
    return (digit <= MAX_DIGIT) && (cur_ones <= MAX_TENS);
  endfunction

endpackage

// File: rtl/keypad_preset_reg.sv
// Three-digit keypad shift register holding the cook-time preset (m:ts:os).
// Illegal keys are dropped so the tens digit never exceeds five.
module keypad_preset_reg
  import microwave_pkg::*;
(
  input  logic clk,
  input  logic clear,
  input  logic sync_clr,
  input  logic shift_en,
  input  bcd_t key_digit,
  output bcd_t ones,
  output bcd_t tens,
  output bcd_t mins
);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      ones <= '0;
      tens <= '0;
      mins <= '0;
    end else if (sync_clr) begin
      ones <= '0;
      tens <= '0;
      mins <= '0;
    end else if (shift_en && key_legal(key_digit, ones)) begin
      mins <= tens;
      tens <= ones;
      ones <= key_digit;
    end
  end

endmodule

// File: rtl/microwave_timer_ctrl.sv
// Cook-timer sequencer: keypad preset capture, countdown enable, door/stop pauses,
// zero detection, magnetron drive and end-of-cook beep timing.
module microwave_timer_ctrl
  import microwave_pkg::*;
#(
  parameter int BEEP_SECS = 3
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       tick_1hz,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop_clear,
  input  logic       door_closed,
  input  logic       zero_ones,
  input  logic       zero_tens,
  input  logic       zero_mins,
  output logic [3:0] preset_ones,
  output logic [3:0] preset_tens,
  output logic [3:0] preset_mins,
  output logic       load_n,
  output logic       count_en,
  output logic       counter_clear_n,
  output logic       magnetron_on,
  output logic       done_beep,
  output logic [1:0] state_dbg
);

  localparam logic [3:0] BEEP_INIT = 4'(BEEP_SECS);

  state_t     state;
  state_t     nxt;
  logic [3:0] beep_cnt;
  logic       all_zero;
  logic       preset_zero;
  logic       clr_req;
  logic       key_shift;
  logic       preset_clr;

  assign all_zero    = zero_ones & zero_tens & zero_mins;
  assign preset_zero = (preset_ones == 4'd0) && (preset_tens == 4'd0) && (preset_mins == 4'd0);
  assign clr_req     = stop_clear && ((state == IDLE) || (state == PAUSE));
  assign key_shift   = (state == IDLE) && key_valid && !stop_clear && !start;
  assign preset_clr  = clr_req || ((state == COOK) && (nxt == DONE));
  assign count_en    = (state == COOK) & tick_1hz & door_closed & ~all_zero;
  assign state_dbg   = state;

  keypad_preset_reg u_preset (
    .clk       (clk),
    .clear     (clear),
    .sync_clr  (preset_clr),
    .shift_en  (key_shift),
    .key_digit (key_digit),
    .ones      (preset_ones),
    .tens      (preset_tens),
    .mins      (preset_mins)
  );

  // Stop/door requests outrank completion so an open door always pauses first.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (!stop_clear && start && door_closed && !preset_zero) nxt = COOK;
      end
      COOK: begin
        if (stop_clear || !door_closed) nxt = PAUSE;
        else if (all_zero)              nxt = DONE;
      end
      PAUSE: begin
        if (stop_clear)                nxt = IDLE;
        else if (start && door_closed) nxt = COOK;
      end
      DONE: begin
        if (stop_clear)                             nxt = IDLE;
        else if (tick_1hz && (beep_cnt <= 4'd1))    nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Moore outputs are registered from the next state so they align with the state register.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state           <= IDLE;
      beep_cnt        <= 4'd0;
      counter_clear_n <= 1'b1;
      magnetron_on    <= 1'b0;
      done_beep       <= 1'b0;
      load_n          <= 1'b0;
    end else begin
      state           <= nxt;
      counter_clear_n <= !clr_req;
      magnetron_on    <= (nxt == COOK);
      done_beep       <= (nxt == DONE);
      load_n          <= (nxt != IDLE);
      if ((state != DONE) && (nxt == DONE)) begin
        beep_cnt <= BEEP_INIT;
      end else if (state == DONE) begin
        if (nxt != DONE)   beep_cnt <= 4'd0;
        else if (tick_1hz) beep_cnt <= beep_cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Self-checking bench for microwave_timer_ctrl: a directed vector table, hand-written
// cook/pause/clear sequences and randomized traffic, all checked against a seconds-based model.
module tb_microwave_timer_ctrl;

  localparam int BEEP = 3;

  logic       clk = 1'b0;
  logic       clear;
  logic       tick_1hz;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       start;
  logic       stop_clear;
  logic       door_closed;
  logic       zero_ones;
  logic       zero_tens;
  logic       zero_mins;
  logic [3:0] preset_ones;
  logic [3:0] preset_tens;
  logic [3:0] preset_mins;
  logic       load_n;
  logic       count_en;
  logic       counter_clear_n;
  logic       magnetron_on;
  logic       done_beep;
  logic [1:0] state_dbg;

  microwave_timer_ctrl #(.BEEP_SECS(BEEP)) dut (
    .clk             (clk),
    .clear           (clear),
    .tick_1hz        (tick_1hz),
    .key_valid       (key_valid),
    .key_digit       (key_digit),
    .start           (start),
    .stop_clear      (stop_clear),
    .door_closed     (door_closed),
    .zero_ones       (zero_ones),
    .zero_tens       (zero_tens),
    .zero_mins       (zero_mins),
    .preset_ones     (preset_ones),
    .preset_tens     (preset_tens),
    .preset_mins     (preset_mins),
    .load_n          (load_n),
    .count_en        (count_en),
    .counter_clear_n (counter_clear_n),
    .magnetron_on    (magnetron_on),
    .done_beep       (done_beep),
    .state_dbg       (state_dbg)
  );

  always #5 clk = ~clk;

  // The external cascaded BCD digit counters the controller drives.
  int c_ones = 0;
  int c_tens = 0;
  int c_mins = 0;
  assign zero_ones = (c_ones == 0);
  assign zero_tens = (c_tens == 0);
  assign zero_mins = (c_mins == 0);

  // Reference model: states by number (0 idle, 1 cook, 2 pause, 3 done), counters as plain seconds.
  int m_state = 0;
  int m_po = 0;
  int m_pt = 0;
  int m_pm = 0;
  int m_beep = 0;
  int m_secs = 0;
  int m_clr_n = 1;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    bit sc;
    bit door;
    bit st;
    bit kv;
    int kd;
    bit tk;
    int e_state;
    int e_preset;
  } vec_t;

  vec_t tbl[18];

  function automatic int preset_secs();
    return m_pm * 60 + m_pt * 10 + m_po;
  endfunction

  function automatic int dut_preset();
    return {20'd0, preset_mins, preset_tens, preset_ones};
  endfunction

  function automatic int display_secs();
    return c_mins * 60 + c_tens * 10 + c_ones;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model_outputs(input int exp_en);
    checkOutput("count_en", int'(count_en), exp_en);
    checkOutput("state_dbg", int'(state_dbg), m_state);
    checkOutput("magnetron_on", int'(magnetron_on), int'(m_state == 1));
    checkOutput("done_beep", int'(done_beep), int'(m_state == 3));
    checkOutput("load_n", int'(load_n), int'(m_state != 0));
    checkOutput("counter_clear_n", int'(counter_clear_n), m_clr_n);
    checkOutput("preset", dut_preset(), (m_pm << 8) | (m_pt << 4) | m_po);
    checkOutput("display_secs", display_secs(), m_secs);
    checkOutput("tens_legal", int'(preset_tens <= 4'd5), 1);
  endtask

  // One clock cycle: drive at the falling edge, check before the rising edge, then advance plant and model.
  task automatic applyStimulus(input bit sc, input bit door, input bit st, input bit kv,
                               input int kd, input bit tk, input bit async_clr);
    int  exp_en;
    int  ns;
    int  nclr;
    bit  cap_load_n;
    bit  cap_en;
    bit  cap_clr_n;
    int  cap_po;
    int  cap_pt;
    int  cap_pm;
    @(negedge clk);
    stop_clear  = sc;
    door_closed = door;
    start       = st;
    key_valid   = kv;
    key_digit   = kd[3:0];
    tick_1hz    = tk;
    if (async_clr) begin
      #1 clear = 1'b1;
      #1;
      checkOutput("clr_magnetron", int'(magnetron_on), 0);
      checkOutput("clr_done_beep", int'(done_beep), 0);
      checkOutput("clr_state", int'(state_dbg), 0);
      checkOutput("clr_load_n", int'(load_n), 0);
      checkOutput("clr_count_en", int'(count_en), 0);
      checkOutput("clr_preset", dut_preset(), 0);
      checkOutput("clr_counter_clear_n", int'(counter_clear_n), 1);
      m_state = 0;
      m_po = 0;
      m_pt = 0;
      m_pm = 0;
      m_beep = 0;
      m_clr_n = 1;
      clear = 1'b0;
    end
    #1;
    exp_en = int'(m_state == 1 && tk && door && m_secs != 0);
    check_model_outputs(exp_en);
    cap_load_n = load_n;
    cap_en     = count_en;
    cap_clr_n  = counter_clear_n;
    cap_po     = int'(preset_ones);
    cap_pt     = int'(preset_tens);
    cap_pm     = int'(preset_mins);

    @(posedge clk);
    #1;
    if (!cap_clr_n) begin
      c_ones = 0; c_tens = 0; c_mins = 0;
    end else if (!cap_load_n) begin
      c_ones = cap_po; c_tens = cap_pt; c_mins = cap_pm;
    end else if (cap_en) begin
      if (c_ones > 0) c_ones--;
      else begin
        c_ones = 9;
        if (c_tens > 0) c_tens--;
        else begin
          c_tens = 5;
          c_mins = (c_mins > 0) ? c_mins - 1 : 9;
        end
      end
    end

    ns = m_secs;
    if (m_clr_n == 0)      ns = 0;
    else if (m_state == 0) ns = preset_secs();
    else if (exp_en != 0)  ns = m_secs - 1;
    nclr = 1;
    case (m_state)
      0: begin
        if (sc) begin
          m_po = 0; m_pt = 0; m_pm = 0; nclr = 0;
        end else if (st && door && preset_secs() != 0) begin
          m_state = 1;
        end else if (kv && !st && kd <= 9 && m_po <= 5) begin
          m_pm = m_pt; m_pt = m_po; m_po = kd;
        end
      end
      1: begin
        if (sc || !door) m_state = 2;
        else if (m_secs == 0) begin
          m_state = 3; m_po = 0; m_pt = 0; m_pm = 0; m_beep = BEEP;
        end
      end
      2: begin
        if (sc) begin
          m_state = 0; m_po = 0; m_pt = 0; m_pm = 0; nclr = 0;
        end else if (st && door) m_state = 1;
      end
      default: begin
        if (sc) m_state = 0;
        else if (tk) begin
          m_beep--;
          if (m_beep == 0) m_state = 0;
        end
      end
    endcase
    m_secs = ns;
    m_clr_n = nclr;
  endtask

  task automatic idle_cycle();
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic press(input int kd);
    applyStimulus(0, 1, 0, 1, kd, 0, 0);
  endtask

  initial begin
    tbl[0]  = '{0, 1, 0, 1, 1,  0, 0, 'h001};
    tbl[1]  = '{0, 1, 0, 1, 3,  0, 0, 'h013};
    tbl[2]  = '{0, 1, 0, 1, 0,  0, 0, 'h130};
    tbl[3]  = '{0, 1, 0, 1, 12, 0, 0, 'h130};
    tbl[4]  = '{0, 1, 0, 1, 15, 0, 0, 'h130};
    tbl[5]  = '{0, 1, 0, 0, 0,  1, 0, 'h130};
    tbl[6]  = '{1, 1, 0, 0, 0,  0, 0, 'h000};
    tbl[7]  = '{0, 1, 1, 0, 0,  0, 0, 'h000};
    tbl[8]  = '{0, 1, 0, 1, 9,  0, 0, 'h009};
    tbl[9]  = '{0, 1, 0, 1, 9,  0, 0, 'h009};
    tbl[10] = '{0, 1, 0, 1, 1,  0, 0, 'h009};
    tbl[11] = '{0, 0, 1, 0, 0,  0, 0, 'h009};
    tbl[12] = '{1, 1, 0, 0, 0,  0, 0, 'h000};
    tbl[13] = '{0, 1, 0, 1, 5,  0, 0, 'h005};
    tbl[14] = '{0, 1, 0, 1, 5,  0, 0, 'h055};
    tbl[15] = '{0, 1, 0, 1, 9,  0, 0, 'h559};
    tbl[16] = '{0, 1, 0, 1, 2,  0, 0, 'h559};
    tbl[17] = '{1, 1, 0, 0, 0,  0, 0, 'h000};

    clear = 1'b1;
    tick_1hz = 0; key_valid = 0; key_digit = 0; start = 0; stop_clear = 0; door_closed = 1;
    repeat (3) @(negedge clk);
    checkOutput("rst_state", int'(state_dbg), 0);
    checkOutput("rst_magnetron", int'(magnetron_on), 0);
    checkOutput("rst_load_n", int'(load_n), 0);
    checkOutput("rst_counter_clear_n", int'(counter_clear_n), 1);
    checkOutput("rst_preset", dut_preset(), 0);
    clear = 1'b0;

    // Directed keypad / idle vectors.
    foreach (tbl[i]) begin
      applyStimulus(tbl[i].sc, tbl[i].door, tbl[i].st, tbl[i].kv, tbl[i].kd, tbl[i].tk, 0);
      checkOutput($sformatf("vec%0d_state", i), int'(state_dbg), tbl[i].e_state);
      checkOutput($sformatf("vec%0d_preset", i), dut_preset(), tbl[i].e_preset);
    end
    idle_cycle();

    // Full cook of 1:30 followed by the end-of-cook beep.
    press(1); press(3); press(0);
    checkOutput("preset_1_30", dut_preset(), 'h130);
    applyStimulus(0, 1, 1, 0, 0, 0, 0);
    checkOutput("cook_magnetron", int'(magnetron_on), 1);
    for (int t = 0; t < 89; t++) begin
      applyStimulus(0, 1, 0, 0, 0, 1, 0);
      repeat (3) idle_cycle();
    end
    applyStimulus(0, 1, 0, 0, 0, 1, 0);
    checkOutput("zero_reached_secs", display_secs(), 0);
    checkOutput("zero_still_cook", int'(state_dbg), 1);
    idle_cycle();
    checkOutput("done_state", int'(state_dbg), 3);
    checkOutput("done_magnetron_off", int'(magnetron_on), 0);
    checkOutput("done_beep_on", int'(done_beep), 1);
    for (int b = 1; b <= BEEP; b++) begin
      idle_cycle();
      applyStimulus(0, 1, 0, 0, 0, 1, 0);
      checkOutput($sformatf("beep_tick%0d_done_beep", b), int'(done_beep), int'(b < BEEP));
    end
    checkOutput("beep_end_state", int'(state_dbg), 0);

    // Door opening on a tick suppresses that tick; resume continues from 0:07.
    press(1); press(0);
    applyStimulus(0, 1, 1, 0, 0, 0, 0);
    repeat (3) begin
      applyStimulus(0, 1, 0, 0, 0, 1, 0);
      idle_cycle();
    end
    checkOutput("door_pre_secs", display_secs(), 7);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    checkOutput("door_pause_state", int'(state_dbg), 2);
    checkOutput("door_hold_secs", display_secs(), 7);
    applyStimulus(0, 1, 1, 0, 0, 0, 0);
    checkOutput("door_resume_state", int'(state_dbg), 1);
    applyStimulus(0, 1, 0, 0, 0, 1, 0);
    checkOutput("door_resume_secs", display_secs(), 6);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    idle_cycle();

    // Stop while cooking pauses; a second stop clears back to idle with a one-cycle clear pulse.
    press(4); press(5);
    applyStimulus(0, 1, 1, 0, 0, 0, 0);
    checkOutput("cook45_secs", display_secs(), 45);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    checkOutput("stop_pause_state", int'(state_dbg), 2);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    checkOutput("clear_idle_state", int'(state_dbg), 0);
    checkOutput("clear_preset", dut_preset(), 0);
    checkOutput("clear_pulse_low", int'(counter_clear_n), 0);
    idle_cycle();
    checkOutput("clear_pulse_high", int'(counter_clear_n), 1);
    checkOutput("clear_display", display_secs(), 0);

    // Asynchronous clear in the middle of a cook at 0:20.
    press(2); press(0);
    applyStimulus(0, 1, 1, 0, 0, 0, 0);
    checkOutput("pre_clr_state", int'(state_dbg), 1);
    applyStimulus(0, 1, 0, 0, 0, 0, 1);
    for (int k = 0; k < 6; k++) applyStimulus(0, 1, 0, 0, 0, k[0], 0);
    checkOutput("post_clr_state", int'(state_dbg), 0);

    // Randomized traffic against the model.
    for (int r = 0; r < 2000; r++) begin
      bit sc, door, st, kv, tk;
      int kd;
      sc   = ($urandom_range(0, 29) == 0);
      door = ($urandom_range(0, 11) != 0);
      st   = ($urandom_range(0, 7) == 0);
      tk   = ($urandom_range(0, 3) == 0);
      kd   = int'($urandom_range(0, 15));
      kv   = 0;
      if (!sc && !st && door) kv = ($urandom_range(0, 2) == 0);
      applyStimulus(sc, door, st, kv, kd, tk, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
